// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative signed multiply / restoring divide unit with HI/LO
//               result registers for the multicycle MIPS datapath.
// Revision    : 1.0  initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mult_start,
  input  logic              div_start,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MULT  = 3'd1,
    S_DIV   = 3'd2,
    S_FIX   = 3'd3,
    S_DZERO = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  state_t                r_state, w_state_nxt;
  logic [2*DATA_W-1:0]   r_acc, w_acc_nxt;
  logic [DATA_W-1:0]     r_opd, w_opd_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_is_div, w_is_div_nxt;
  logic                  r_neg_q, w_neg_q_nxt;
  logic                  r_neg_r, w_neg_r_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_dz, w_dz_nxt;
  logic [DATA_W-1:0]     r_hi, w_hi_nxt;
  logic [DATA_W-1:0]     r_lo, w_lo_nxt;

  logic [DATA_W-1:0]     w_a_mag, w_b_mag;
  logic [DATA_W:0]       w_madd;
  logic [2*DATA_W-1:0]   w_mult_acc;
  logic [DATA_W:0]       w_dshift, w_dtrial;
  logic [2*DATA_W-1:0]   w_div_acc;
  logic [2*DATA_W-1:0]   w_prod;
  logic [DATA_W-1:0]     w_quo, w_rem;

  assign w_a_mag = a_in[DATA_W-1] ? -a_in : a_in;
  assign w_b_mag = b_in[DATA_W-1] ? -b_in : b_in;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign w_madd     = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, (r_acc[0] ? r_opd : {DATA_W{1'b0}})};
  assign w_mult_acc = {w_madd, r_acc[DATA_W-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; quotient bits enter at the LSB.
  assign w_dshift  = r_acc[2*DATA_W-1:DATA_W-1];
  assign w_dtrial  = w_dshift - {1'b0, r_opd};
  assign w_div_acc = w_dtrial[DATA_W] ? {w_dshift[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0}
                                      : {w_dtrial[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_opd_nxt    = r_opd;
    w_cnt_nxt    = r_cnt;
    w_is_div_nxt = r_is_div;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_dz_nxt     = 1'b0;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    case (r_state)
      S_IDLE: begin
        if (mult_start) begin
          w_state_nxt  = S_MULT;
          w_acc_nxt    = {{DATA_W{1'b0}}, w_b_mag};
          w_opd_nxt    = w_a_mag;
          w_cnt_nxt    = '0;
          w_is_div_nxt = 1'b0;
          w_neg_q_nxt  = a_in[DATA_W-1] ^ b_in[DATA_W-1];
          w_neg_r_nxt  = 1'b0;
          w_busy_nxt   = 1'b1;
        end else if (div_start) begin
          w_busy_nxt = 1'b1;
          if (b_in == '0) begin
            w_state_nxt = S_DZERO;
          end else begin
            w_state_nxt  = S_DIV;
            w_acc_nxt    = {{DATA_W{1'b0}}, w_a_mag};
            w_opd_nxt    = w_b_mag;
            w_cnt_nxt    = '0;
            w_is_div_nxt = 1'b1;
            w_neg_q_nxt  = a_in[DATA_W-1] ^ b_in[DATA_W-1];
            w_neg_r_nxt  = a_in[DATA_W-1];
          end
        end
      end
      S_MULT: begin
        w_acc_nxt = w_mult_acc;
        w_cnt_nxt = r_cnt + C_CNT_ONE;
        if (r_cnt == C_LAST) w_state_nxt = S_FIX;
      end
      S_DIV: begin
        w_acc_nxt = w_div_acc;
        w_cnt_nxt = r_cnt + C_CNT_ONE;
        if (r_cnt == C_LAST) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        if (r_is_div) begin
          w_hi_nxt = w_rem;
          w_lo_nxt = w_quo;
        end else begin
          w_hi_nxt = w_prod[2*DATA_W-1:DATA_W];
          w_lo_nxt = w_prod[DATA_W-1:0];
        end
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      S_DZERO: begin
        w_done_nxt  = 1'b1;
        w_dz_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_opd    <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_opd    <= w_opd_nxt;
      r_cnt    <= w_cnt_nxt;
      r_is_div <= w_is_div_nxt;
      r_neg_q  <= w_neg_q_nxt;
      r_neg_r  <= w_neg_r_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_dz     <= w_dz_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_dz;
  assign hi_out   = r_hi;
  assign lo_out   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Directed self-checking bench for muldiv_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_sequencer;

  logic        clock;
  logic        reset;
  logic        mult_start;
  logic        div_start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
    .clock      (clock),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at #1 after a rising edge; returns at the same phase one cycle after done.
  task automatic run_op(input string tag, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dz);
    int lat;
    int busy_cnt;
    mult_start = m;
    div_start  = d;
    a_in       = a;
    b_in       = b;
    @(posedge clock); #1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    a_in       = $urandom;
    b_in       = $urandom;
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clock); #1;
      lat++;
      if (busy) busy_cnt++;
    end
    check_val({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_val({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check_val({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check_val({tag, "_hi"}, 64'(hi_out), 64'(exp_hi));
    check_val({tag, "_lo"}, 64'(lo_out), 64'(exp_lo));
    check_val({tag, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
    @(posedge clock); #1;
    check_val({tag, "_done_clear"}, 64'(done), 64'd0);
    check_val({tag, "_dz_clear"}, 64'(div_zero), 64'd0);
  endtask

  initial begin
    int ndone;
    reset      = 1'b1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    a_in       = '0;
    b_in       = '0;
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_dz", 64'(div_zero), 64'd0);
    check_val("rst_hi", 64'(hi_out), 64'd0);
    check_val("rst_lo", 64'(lo_out), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_op("mul_7_m3",   1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("div_m7_2",   1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_7_m2",   1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op("mul_m5_m6",  1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 33, 32'd0, 32'd30, 1'b0);
    run_op("div_59_6",   1'b0, 1'b1, 32'd59, 32'd6, 33, 32'd5, 32'd9, 1'b0);
    run_op("div_by_0",   1'b0, 1'b1, 32'd1234, 32'd0, 1, 32'd5, 32'd9, 1'b1);
    run_op("mul_min_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'd0, 1'b0);
    run_op("div_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 1'b0);
    run_op("both_start", 1'b1, 1'b1, 32'd6, 32'd7, 33, 32'd0, 32'd42, 1'b0);

    // A div request at cycle 10 of a multiply must be dropped.
    mult_start = 1'b1;
    a_in       = 32'd3;
    b_in       = 32'd5;
    @(posedge clock); #1;
    mult_start = 1'b0;
    ndone      = 0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clock); #1;
      if (done) ndone++;
      if (i == 9) begin
        div_start = 1'b1;
        a_in      = 32'd100;
        b_in      = 32'd7;
      end else begin
        div_start = 1'b0;
      end
    end
    check_val("busy_start_done_count", 64'(ndone), 64'd1);
    check_val("busy_start_hi", 64'(hi_out), 64'd0);
    check_val("busy_start_lo", 64'(lo_out), 64'd15);
    check_val("busy_start_idle", 64'(busy), 64'd0);

    // Reset asserted part-way through a divide.
    div_start = 1'b1;
    a_in      = 32'd100;
    b_in      = 32'd7;
    @(posedge clock); #1;
    div_start = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    check_val("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check_val("mid_rst_busy", 64'(busy), 64'd0);
    check_val("mid_rst_hi", 64'(hi_out), 64'd0);
    check_val("mid_rst_lo", 64'(lo_out), 64'd0);
    ndone = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (done) ndone++;
    end
    reset = 1'b0;
    repeat (25) begin
      @(posedge clock); #1;
      if (done) ndone++;
    end
    check_val("mid_rst_no_done", 64'(ndone), 64'd0);
    run_op("mul_after_rst", 1'b1, 1'b0, 32'd4, 32'd5, 33, 32'd0, 32'd20, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
